// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register pending-write scoreboard
// Optional write-through forwarding and busy suppression under macro REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  r_cnt  [DEPTH];

    logic              w_wb_we;
    logic [DEPTH-1:0]  w_inc;
    logic [DEPTH-1:0]  w_dec;
    logic [CNT_W-1:0]  w_rs_cnt;
    logic [CNT_W-1:0]  w_rt_cnt;
    logic [DATA_W-1:0] w_rs_stored;
    logic [DATA_W-1:0] w_rt_stored;

    assign w_wb_we = wb_en && (wb_addr != '0);

    // Overflow check looks at the current count only, never at a same-cycle writeback.
    assign iss_ready = (iss_addr == '0) || (r_cnt[iss_addr] != CNT_MAX);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_inc[i] = iss_en && iss_ready && (iss_addr == i[ADDR_W-1:0]);
            w_dec[i] = wb_en && (wb_addr == i[ADDR_W-1:0]) && (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Flush wins over any issue or retire in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign w_rs_cnt    = r_cnt[rs_addr];
    assign w_rt_cnt    = r_cnt[rt_addr];
    assign w_rs_stored = (rs_addr == '0) ? '0 : r_regs[rs_addr];
    assign w_rt_stored = (rt_addr == '0) ? '0 : r_regs[rt_addr];

`ifdef REGFILE_BYPASS_EN
    logic w_rs_fwd;
    logic w_rt_fwd;

    assign w_rs_fwd = w_wb_we && (wb_addr == rs_addr);
    assign w_rt_fwd = w_wb_we && (wb_addr == rt_addr);
    assign rs_data  = w_rs_fwd ? wb_data : w_rs_stored;
    assign rt_data  = w_rt_fwd ? wb_data : w_rt_stored;
    // The last outstanding writer retiring this cycle already supplies the data.
    assign rs_busy  = (rs_addr != '0) && (w_rs_cnt != '0) &&
                      !(w_rs_fwd && (w_rs_cnt == CNT_W'(1)));
    assign rt_busy  = (rt_addr != '0) && (w_rt_cnt != '0) &&
                      !(w_rt_fwd && (w_rt_cnt == CNT_W'(1)));
`else
    assign rs_data  = w_rs_stored;
    assign rt_data  = w_rt_stored;
    assign rs_busy  = (rs_addr != '0) && (w_rs_cnt != '0);
    assign rt_busy  = (rt_addr != '0) && (w_rt_cnt != '0);
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_scoreboard;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    localparam int S_RS_DATA = 0;
    localparam int S_RT_DATA = 1;
    localparam int S_RS_BUSY = 2;
    localparam int S_RT_BUSY = 3;
    localparam int S_ISS_RDY = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rs_addr, rt_addr, iss_addr, wb_addr;
    logic [DATA_W-1:0] rs_data, rt_data, wb_data;
    logic              rs_busy, rt_busy, iss_en, iss_ready, wb_en, flush;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are combinational, so they are sampled at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = q.pop_front();
            case (c.sel)
                S_RS_DATA: act = rs_data;
                S_RT_DATA: act = rt_data;
                S_RS_BUSY: act = {31'd0, rs_busy};
                S_RT_BUSY: act = {31'd0, rt_busy};
                default:   act = {31'd0, iss_ready};
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] e, input string n);
        chk_t c;
        c.sel  = sel;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0;
        wb_en  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    initial begin
        reset = 1'b1;
        rs_addr = '0; rt_addr = '0; iss_addr = '0; wb_addr = '0; wb_data = '0;
        idle();
        tick();
        rs_addr = 5; rt_addr = 7; iss_addr = 5;
        expect_val(S_RS_DATA, 32'h0, "reset_rs_data");
        expect_val(S_RT_DATA, 32'h0, "reset_rt_data");
        expect_val(S_RS_BUSY, 32'h0, "reset_rs_busy");
        expect_val(S_RT_BUSY, 32'h0, "reset_rt_busy");
        expect_val(S_ISS_RDY, 32'h1, "reset_iss_ready");
        tick();
        reset = 1'b0;

        // Basic write/read, and r0 stays zero
        rs_addr = 7; wb(7, 32'h12345678);
        expect_val(S_RS_DATA, BYP ? 32'h12345678 : 32'h0, "wb7_same_cycle");
        tick();
        idle();
        expect_val(S_RS_DATA, 32'h12345678, "wb7_next_cycle");
        wb(0, 32'hFFFFFFFF); rt_addr = 0;
        tick();
        idle();
        expect_val(S_RT_DATA, 32'h0, "r0_read_zero");
        expect_val(S_RT_BUSY, 32'h0, "r0_not_busy");

        // Scoreboard on r3: two issues, two retires
        issue(3); rt_addr = 3;
        expect_val(S_ISS_RDY, 32'h1, "r3_iss_ready0");
        tick();
        expect_val(S_RT_BUSY, 32'h1, "r3_busy_cnt1");
        tick();
        idle();
        wb(3, 32'h33);
        expect_val(S_RT_BUSY, 32'h1, "r3_busy_cnt2_wb");
        tick();
        idle();
        expect_val(S_RT_BUSY, 32'h1, "r3_busy_after_wb1");
        expect_val(S_RT_DATA, 32'h33, "r3_data_wb1");
        wb(3, 32'h34);
        expect_val(S_RT_BUSY, BYP ? 32'h0 : 32'h1, "r3_busy_last_wb");
        tick();
        idle();
        expect_val(S_RT_BUSY, 32'h0, "r3_busy_clear");
        expect_val(S_RT_DATA, 32'h34, "r3_data_wb2");

        // Saturation on r4
        rs_addr = 4;
        for (int i = 0; i < 3; i++) begin
            issue(4);
            expect_val(S_ISS_RDY, 32'h1, "r4_iss_ready_fill");
            tick();
        end
        issue(4);
        expect_val(S_ISS_RDY, 32'h0, "r4_iss_ready_full");
        expect_val(S_RS_BUSY, 32'h1, "r4_busy_full");
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            wb(4, 32'h40 + i);
            expect_val(S_RS_BUSY, (BYP && i == 2) ? 32'h0 : 32'h1, "r4_busy_drain");
            tick();
            idle();
        end
        iss_addr = 4;
        expect_val(S_RS_BUSY, 32'h0, "r4_busy_clear");
        expect_val(S_ISS_RDY, 32'h1, "r4_iss_ready_clear");
        wb(4, 32'h44);
        tick();
        idle();
        expect_val(S_RS_BUSY, 32'h0, "r4_no_underflow");
        expect_val(S_ISS_RDY, 32'h1, "r4_ready_no_underflow");
        expect_val(S_RS_DATA, 32'h44, "r4_underflow_write");

        // Simultaneous issue + writeback on r9, then flush
        issue(9);
        tick();
        issue(9); wb(9, 32'h99);
        expect_val(S_ISS_RDY, 32'h1, "r9_iss_ready");
        tick();
        idle();
        rs_addr = 9;
        expect_val(S_RS_BUSY, 32'h1, "r9_cnt_held");
        expect_val(S_RS_DATA, 32'h99, "r9_data");
        issue(10);
        tick();
        idle();
        flush = 1'b1; issue(9); wb(11, 32'hBB);
        tick();
        idle();
        rs_addr = 9; rt_addr = 10;
        expect_val(S_RS_BUSY, 32'h0, "flush_r9_busy");
        expect_val(S_RT_BUSY, 32'h0, "flush_r10_busy");
        tick();
        rt_addr = 11;
        expect_val(S_RT_DATA, 32'hBB, "flush_wb_data");

        // Bypass / no-bypass on r2
        issue(2);
        tick();
        idle();
        rs_addr = 2; wb(2, 32'hA5A5A5A5);
        expect_val(S_RS_DATA, BYP ? 32'hA5A5A5A5 : 32'h0, "r2_bypass_data");
        expect_val(S_RS_BUSY, BYP ? 32'h0 : 32'h1, "r2_bypass_busy");
        tick();
        idle();
        expect_val(S_RS_DATA, 32'hA5A5A5A5, "r2_data_after");
        expect_val(S_RS_BUSY, 32'h0, "r2_busy_after");

        // Reset mid-run, asserted between edges
        wb(5, 32'hDEADBEEF);
        tick();
        idle();
        issue(5);
        tick();
        idle();
        rs_addr = 5; iss_addr = 5;
        expect_val(S_RS_DATA, 32'hDEADBEEF, "r5_before_reset");
        expect_val(S_RS_BUSY, 32'h1, "r5_busy_before_reset");
        tick();
        #1;
        reset = 1'b1;
        expect_val(S_RS_DATA, 32'h0, "r5_after_reset");
        expect_val(S_RS_BUSY, 32'h0, "r5_busy_after_reset");
        expect_val(S_ISS_RDY, 32'h1, "iss_ready_after_reset");
        tick();
        reset = 1'b0;

        for (int i = 0; i < 5 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
